data_mem_master: RTL and testbench

Initiator-side controller for the word-organised data RAM of the MIPS datapath. It accepts one load/store request at a time from the execute/memory stage, drives the RAM's address, write-data, write-enable and read-enable lines, and returns the result to the pipeline. Byte and halfword stores are implemented as read-modify-write on the 32-bit word. The RAM read path is combinational; its write takes effect on the rising clock edge.

---
 rtl/data_mem_master.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_master.sv
// Load/store initiator for the word-organised data RAM; sub-word stores are read-modify-write.
// Optional build macro DMM_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module data_mem_master #(
  parameter int unsigned ADDR_LIMIT = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_write,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  typedef struct packed {
    logic          write;
    logic [1:0]    size;
    logic          sign;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;

  logic [1:0]    size_n;
  logic [AW-1:0] eff_addr;
  logic          req_err;

  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      SZ_B:    load_extract = sign ? {{24{b[7]}}, b} : {24'h0, b};
      SZ_H:    load_extract = sign ? {{16{h[15]}}, h} : {16'h0, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] old, input logic [DW-1:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
    case (size)
      SZ_B: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {24'h0, wdata[7:0]} << {lane, 3'b000};
      end
      SZ_H: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = {16'h0, wdata[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = '1;
        data = wdata;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  // Request decode: size normalisation, natural alignment and error classification
  always_comb begin
    size_n = (req_size == 2'b11) ? SZ_W : req_size;
    case (size_n)
      SZ_H:    eff_addr = {req_addr[31:1], 1'b0};
      SZ_W:    eff_addr = {req_addr[31:2], 2'b00};
      default: eff_addr = req_addr;
    endcase
    req_err = (eff_addr >= AW'(ADDR_LIMIT));
`ifdef DMM_MISALIGN_CHECK_EN
    if ((size_n == SZ_H && req_addr[0]) || (size_n == SZ_W && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`endif
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    rdata_d  = '0;
    maddr_d  = '0;
    mwdata_d = '0;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          req_d   = '{write: req_write, size: size_n, sign: req_signed, addr: eff_addr, wdata: req_wdata};
          if (req_err) begin
            state_d = S_RESP;
            valid_d = 1'b1;
            error_d = 1'b1;
          end else if (req_write && size_n == SZ_W) begin
            state_d  = S_WRITE;
            wen_d    = 1'b1;
            maddr_d  = {eff_addr[31:2], 2'b00};
            mwdata_d = req_wdata;
          end else begin
            state_d = S_READ;
            ren_d   = 1'b1;
            maddr_d = {eff_addr[31:2], 2'b00};
          end
        end
      end
      S_READ: begin
        if (req_q.write) begin
          state_d  = S_WRITE;
          wen_d    = 1'b1;
          maddr_d  = {req_q.addr[31:2], 2'b00};
          mwdata_d = store_merge(mem_data_out, req_q.wdata, req_q.size, req_q.addr[1:0]);
        end else begin
          state_d = S_RESP;
          valid_d = 1'b1;
          rdata_d = load_extract(mem_data_out, req_q.size, req_q.addr[1:0], req_q.sign);
        end
      end
      S_WRITE: begin
        state_d = S_RESP;
        valid_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
    end
  end

  assign req_ready      = ready_q;
  assign resp_valid     = valid_q;
  assign resp_error     = error_q;
  assign resp_rdata     = rdata_q;
  assign mem_address    = maddr_q;
  assign mem_data_write = mwdata_q;
  assign mem_read_en    = ren_q;
  // A write pending when reset rises must never reach the RAM
  assign mem_write_en   = wen_q & ~reset;

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master with a behavioural word RAM.
module tb_data_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_write, mem_data_out;
  logic        mem_write_en, mem_read_en;

  logic [31:0] ram [0:31];
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  data_mem_master #(.ADDR_LIMIT(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_data_out(mem_data_out)
  );

  assign mem_data_out = ram[mem_address[6:2]];

  always @(posedge clk) begin
    if (mem_write_en) ram[mem_address[6:2]] <= mem_data_write;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and record per-cycle strobes/response for cycles T+1..T+7 (bit k = T+k)
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output int rc, output logic [31:0] rd, output logic er,
                       output logic [7:0] rb, output logic [7:0] wb, output logic [7:0] vb,
                       output logic [31:0] wseen);
    int n;
    rc = 0; rd = '0; er = 1'b0; rb = '0; wb = '0; vb = '0; wseen = '0; n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_5555;
    for (int k = 1; k < 8; k++) begin
      rb[k] = mem_read_en;
      wb[k] = mem_write_en;
      vb[k] = resp_valid;
      if (mem_write_en) wseen = mem_data_write;
      if (resp_valid && rc == 0) begin
        rc = k; rd = resp_rdata; er = resp_error;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    ntests++;
    if ({req_ready, resp_valid, resp_error, mem_write_en, mem_read_en} !== 5'b0 ||
        mem_address !== 32'h0 || resp_rdata !== 32'h0 || mem_data_write !== 32'h0) begin
      nfail++;
      $display("FAIL reset_outputs: ready=%b valid=%b addr=%h wdata=%h want all zero",
               req_ready, resp_valid, mem_address, mem_data_write);
    end
    reset = 1'b0;
    tick();
    ntests++;
    if (req_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_load();
    int rc; logic [31:0] rd, ws; logic er; logic [7:0] rb, wb, vb;
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || rd !== 32'h0000_0003 || er !== 1'b0) begin
      nfail++;
      $display("FAIL lw_0x8: cyc=%0d data=%h err=%b want cyc=2 data=00000003 err=0", rc, rd, er);
    end
    ntests++;
    if (rb !== 8'b0000_0010 || wb !== 8'h00 || vb !== 8'b0000_0100) begin
      nfail++;
      $display("FAIL lw_strobes: ren=%b wen=%b valid=%b want 00000010 00000000 00000100", rb, wb, vb);
    end
    ntests++;
    if (mem_address !== 32'h0 || req_ready !== 1'b1) begin
      nfail++;
      $display("FAIL idle_after_lw: addr=%h ready=%b want 0 1", mem_address, req_ready);
    end
  endtask

  task automatic test_subword_load();
    int rc; logic [31:0] rd, ws; logic er; logic [7:0] rb, wb, vb;
    issue(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || rd !== 32'hFFFF_FFFF) begin
      nfail++; $display("FAIL lb_0x6: cyc=%0d data=%h want 2 ffffffff", rc, rd);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || rd !== 32'h0000_0080) begin
      nfail++; $display("FAIL lbu_0x7: cyc=%0d data=%h want 2 00000080", rc, rd);
    end
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || rd !== 32'hFFFF_80FF) begin
      nfail++; $display("FAIL lh_0x6: cyc=%0d data=%h want 2 ffff80ff", rc, rd);
    end
    issue(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rd !== 32'h0000_7F01) begin
      nfail++; $display("FAIL lhu_0x4: data=%h want 00007f01", rd);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rd !== 32'h0000_007F) begin
      nfail++; $display("FAIL lb_0x5: data=%h want 0000007f", rd);
    end
  endtask

  task automatic test_subword_store();
    int rc; logic [31:0] rd, ws; logic er; logic [7:0] rb, wb, vb;
    issue(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_00AB, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rb !== 8'b0000_0010 || wb !== 8'b0000_0100 || vb !== 8'b0000_1000 || ws !== 32'h1122_AB44) begin
      nfail++;
      $display("FAIL sb_0x1: ren=%b wen=%b valid=%b wdata=%h want 00000010 00000100 00001000 1122ab44",
               rb, wb, vb, ws);
    end
    ntests++;
    if (rc !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      nfail++; $display("FAIL sb_resp: cyc=%0d data=%h err=%b want 3 0 0", rc, rd, er);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rd !== 32'h1122_AB44) begin
      nfail++; $display("FAIL lw_after_sb: data=%h want 1122ab44", rd);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF, rc, rd, er, rb, wb, vb, ws);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rd !== 32'hBEEF_AB44) begin
      nfail++; $display("FAIL lw_after_sh: data=%h want beefab44", rd);
    end
  endtask

  task automatic test_word_store();
    int rc; logic [31:0] rd, ws; logic er; logic [7:0] rb, wb, vb;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || rb !== 8'h00 || wb !== 8'b0000_0010 || ws !== 32'hCAFE_F00D) begin
      nfail++;
      $display("FAIL sw_0x10: cyc=%0d ren=%b wen=%b wdata=%h want 2 00000000 00000010 cafef00d",
               rc, rb, wb, ws);
    end
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || rd !== 32'hCAFE_F00D) begin
      nfail++; $display("FAIL lw_size11_0x10: cyc=%0d data=%h want 2 cafef00d", rc, rd);
    end
  endtask

  task automatic test_errors();
    int rc; logic [31:0] rd, ws; logic er; logic [7:0] rb, wb, vb;
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h1234_5678, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 1 || er !== 1'b1 || rb !== 8'h00 || wb !== 8'h00 || vb !== 8'b0000_0010) begin
      nfail++;
      $display("FAIL sw_0x80_range: cyc=%0d err=%b ren=%b wen=%b valid=%b want 1 1 0 0 00000010",
               rc, er, rb, wb, vb);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h7F, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rc !== 2 || er !== 1'b0 || rd !== 32'hFFFF_FFA5) begin
      nfail++; $display("FAIL lb_0x7f_edge: cyc=%0d err=%b data=%h want 2 0 ffffffa5", rc, er, rd);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rc, rd, er, rb, wb, vb, ws);
`ifdef DMM_MISALIGN_CHECK_EN
    ntests++;
    if (rc !== 1 || er !== 1'b1 || rb !== 8'h00 || wb !== 8'h00) begin
      nfail++; $display("FAIL lw_0x6_misalign: cyc=%0d err=%b ren=%b wen=%b want 1 1 0 0", rc, er, rb, wb);
    end
`else
    ntests++;
    if (rc !== 2 || er !== 1'b0 || rd !== 32'h80FF_7F01) begin
      nfail++; $display("FAIL lw_0x6_aligned: cyc=%0d err=%b data=%h want 2 0 80ff7f01", rc, er, rd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int rc; logic [31:0] rd, ws; logic er; logic [7:0] rb, wb, vb;
    logic seen_valid;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'hC; req_wdata = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    ntests++;
    if (mem_write_en !== 1'b0) begin
      nfail++; $display("FAIL reset_mid_wen: got %b want 0", mem_write_en);
    end
    tick();
    reset = 1'b0;
    seen_valid = resp_valid;
    tick();
    ntests++;
    if (req_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_mid_ready: got %b want 1", req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      seen_valid |= resp_valid;
      tick();
    end
    ntests++;
    if (seen_valid !== 1'b0) begin
      nfail++; $display("FAIL reset_mid_resp: got %b want 0", seen_valid);
    end
    issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, rc, rd, er, rb, wb, vb, ws);
    ntests++;
    if (rd !== 32'h0) begin
      nfail++; $display("FAIL reset_mid_ram: data=%h want 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] want  [4];
    logic [31:0] got   [4];
    int rdy_cyc [4];
    int idx, nr, nrdy;
    logic acc;
    addrs = '{32'h0, 32'h4, 32'h8, 32'h10};
    want  = '{32'hBEEF_AB44, 32'h80FF_7F01, 32'h0000_0003, 32'hCAFE_F00D};
    idx = 0; nr = 0; nrdy = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = addrs[0];
    for (int c = 0; c < 16; c++) begin
      if (resp_valid && nr < 4) begin got[nr] = resp_rdata; nr++; end
      if (req_ready && nrdy < 4) begin rdy_cyc[nrdy] = c; nrdy++; end
      acc = req_ready && req_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) req_addr = addrs[idx];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    ntests++;
    if (nr !== 4 || nrdy !== 4) begin
      nfail++; $display("FAIL b2b_counts: resp=%0d ready=%0d want 4 4", nr, nrdy);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ntests++;
        if (got[i] !== want[i]) begin
          nfail++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], want[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        ntests++;
        if (rdy_cyc[i] - rdy_cyc[i-1] !== 3) begin
          nfail++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, rdy_cyc[i] - rdy_cyc[i-1]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 32; i++) ram[i] = 32'h0;
    ram[0]  = 32'h1122_3344;
    ram[1]  = 32'h80FF_7F01;
    ram[2]  = 32'h0000_0003;
    ram[31] = 32'hA500_0000;
    test_reset();
    test_word_load();
    test_subword_load();
    test_subword_store();
    test_word_store();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
